// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word geometry, opcodes and fetch FSM states.
package cpu_pkg;

    localparam int I_WIDTH = 12;
    localparam int OPC_W   = 6;
    localparam int IMM_W   = 3;
    localparam int OFS_W   = 3;

    localparam logic [OPC_W-1:0] OPC_MUL = 6'b000001;
    localparam logic [OPC_W-1:0] OPC_ADD = 6'b000010;
    localparam logic [OPC_W-1:0] OPC_END = 6'b000011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Program counter, instruction register and fetch FSM in front of program_memory.
// Handshake: the IR transfers on a rising edge where instr_valid && instr_ready.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [I_WIDTH-1:0]    instruction,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [OPC_W-1:0]      opcode,
    output logic [IMM_W-1:0]      imm,
    output logic [OFS_W-1:0]      offset,
    output logic                  busy,
    output logic                  halted,
    output logic                  overrun,
    output logic [1:0]            state
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_HALT = HALT;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [I_WIDTH-1:0]    ir_q;
    logic                  valid_q;
    logic                  halted_q;
    logic                  overrun_q;

    logic load;
    logic end_word;

    // PC, IR and FSM all advance on the same load enable.
    assign load     = !valid_q || instr_ready;
    assign end_word = (instruction[I_WIDTH-1 -: OPC_W] == OPC_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        pc_q      <= '0;
                        halted_q  <= 1'b0;
                        overrun_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (load) begin
                        pc_q <= pc_q + ADDR_WIDTH'(1);
                        if (end_word) begin
                            // END is swallowed here; the datapath never sees it.
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else begin
                            ir_q    <= instruction;
                            valid_q <= 1'b1;
                            if (pc_q == LAST_ADDR) begin
                                halted_q  <= 1'b1;
                                overrun_q <= 1'b1;
                                state_q   <= ST_HALT;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    // A pending word must drain before a restart is honoured.
                    if (valid_q) begin
                        if (instr_ready) begin
                            valid_q <= 1'b0;
                        end
                    end else if (start) begin
                        state_q   <= ST_RUN;
                        pc_q      <= '0;
                        halted_q  <= 1'b0;
                        overrun_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign address     = pc_q;
    assign instr_valid = valid_q;
    assign opcode      = ir_q[I_WIDTH-1 -: OPC_W];
    assign imm         = ir_q[OFS_W +: IMM_W];
    assign offset      = ir_q[OFS_W-1:0];
    assign busy        = (state_q == ST_RUN);
    assign halted      = halted_q;
    assign overrun     = overrun_q;
    assign state       = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch with a program-walking reference model.
module tb_instruction_fetch;
    import cpu_pkg::*;

    localparam int AW    = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          instr_ready = 1'b0;
    logic [11:0]   instruction;
    logic [AW-1:0] address;
    logic          instr_valid;
    logic [5:0]    opcode;
    logic [2:0]    imm;
    logic [2:0]    offset;
    logic          busy;
    logic          halted;
    logic          overrun;
    logic [1:0]    state;

    logic [11:0]   mem [DEPTH];
    logic [11:0]   exp_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign instruction = mem[address];

    instruction_fetch #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction),
        .address(address), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .imm(imm), .offset(offset), .busy(busy),
        .halted(halted), .overrun(overrun), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_address", 32'(address), 0);
        check("rst_ir", 32'({opcode, imm, offset}), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_state", 32'(state), 32'(IDLE));
    endtask

    function automatic logic [11:0] word(input logic [5:0] op, input int i, input int o);
        logic [2:0] iv = 3'(i);
        logic [2:0] ov = 3'(o);
        return {op, iv, ov};
    endfunction

    task automatic load_reference();
        for (int k = 0; k < 5; k++) begin
            mem[2*k]   = word(OPC_MUL, k, k - 2);
            mem[2*k+1] = word(OPC_ADD, k, k);
        end
        mem[10] = word(OPC_END, 0, 0);
        for (int a = 11; a < DEPTH; a++) mem[a] = word(OPC_ADD, a, a);
    endtask

    task automatic load_random(input int end_pos);
        for (int a = 0; a < DEPTH; a++) begin
            logic [11:0] w = 12'($urandom);
            if (w[11:6] == OPC_END) w[11:6] = 6'b000000;
            mem[a] = w;
        end
        if (end_pos < DEPTH) mem[end_pos] = word(OPC_END, 0, 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: 3-cycle stall while mem[2] is held
    task automatic run_program(input int mode);
        logic [AW-1:0] exp_addr = '0;
        logic          exp_ovr = 1'b1;
        logic          prev_stall = 1'b0;
        logic [11:0]   held_ir = '0;
        logic [AW-1:0] held_addr = '0;
        int            n_words;
        int            cycles = 0;
        int            stall_cnt = 0;
        bit            done = 0;

        exp_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            if (mem[a][11:6] == OPC_END) begin
                exp_addr = AW'(a + 1);
                exp_ovr  = 1'b0;
                break;
            end
            exp_q.push_back(mem[a]);
        end
        n_words = exp_q.size();

        instr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("lat_busy", 32'(busy), 1);
        check("lat_valid0", 32'(instr_valid), 0);
        check("lat_halted_clr", 32'(halted), 0);
        check("lat_overrun_clr", 32'(overrun), 0);
        @(negedge clk);
        if (n_words == 0) begin
            check("end0_halted", 32'(halted), 1);
            check("end0_valid", 32'(instr_valid), 0);
        end else begin
            check("lat_first_valid", 32'(instr_valid), 1);
        end

        while (cycles < 600) begin
            if (prev_stall) begin
                check("stall_ir", 32'({opcode, imm, offset}), 32'(held_ir));
                check("stall_addr", 32'(address), 32'(held_addr));
                check("stall_valid", 32'(instr_valid), 1);
            end
            if (halted && !instr_valid) begin
                done = 1;
                break;
            end
            case (mode)
                0: instr_ready = 1'b1;
                1: instr_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    instr_ready = !(instr_valid && address == 3 && stall_cnt < 3);
                    if (!instr_ready) stall_cnt++;
                end
            endcase
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 32'({opcode, imm, offset}), 32'hFFFF_FFFF);
                end else begin
                    check("issued_word", 32'({opcode, imm, offset}), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = instr_valid && !instr_ready;
            held_ir    = {opcode, imm, offset};
            held_addr  = address;
            @(negedge clk);
            cycles++;
        end

        check("no_timeout", 32'(done), 1);
        check("all_issued", 32'(exp_q.size()), 0);
        check("final_halted", 32'(halted), 1);
        check("final_valid", 32'(instr_valid), 0);
        check("final_overrun", 32'(overrun), 32'(exp_ovr));
        check("final_address", 32'(address), 32'(exp_addr));
        check("final_busy", 32'(busy), 0);
        if (mode == 0) check("throughput", 32'(cycles), 32'(n_words));
        if (mode == 2) check("stall_seen", 32'(stall_cnt), 3);
    endtask

    task automatic wait_address(input logic [AW-1:0] a, input string tag);
        int n = 0;
        while (address != a && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(address), 32'(a));
    endtask

    initial begin
        load_reference();
        repeat (2) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();

        run_program(0);
        run_program(2);
        run_program(1);

        for (int it = 0; it < 6; it++) begin
            load_random($urandom_range(0, 90));
            run_program(1);
        end

        load_reference();
        mem[0] = word(OPC_END, 0, 0);
        run_program(0);

        for (int a = 0; a < DEPTH; a++) mem[a] = word(OPC_ADD, a, a + 1);
        run_program(0);
        for (int a = 0; a < DEPTH; a++) mem[a] = word(6'($urandom_range(4, 63)), a, a);
        run_program(1);

        // start during RUN is ignored, then reset lands mid-stall at PC=5
        load_reference();
        instr_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_address(2, "reach_pc2");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_run_addr", 32'(address), 3);
        check("start_in_run_busy", 32'(busy), 1);
        wait_address(5, "reach_pc5");
        instr_ready = 1'b0;
        @(negedge clk);
        check("stall_pc5", 32'(address), 5);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();

        run_program(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
